// File: rtl/fifo_wr_arbiter.sv
// Round-robin packet arbiter feeding one FIFO write port: a grant is held for a
// whole packet (until last, or a forced release at MAX_BEATS) and stalls on true full.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BEATS  = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  input  logic                          fifo_prog_full,
  output logic                          wr_en,
  output logic [DATA_WIDTH-1:0]         wr_data,
  output logic [2:0]                    grant_idx,
  output logic                          busy,
  output logic                          len_err
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_BEATS) + 1;

  typedef enum logic {IDLE, BURST} state_t;

  state_t           state, state_nxt;
  logic [2:0]       rr_ptr, rr_ptr_nxt, grant_nxt;
  logic [CNT_W-1:0] beat_cnt, beat_cnt_nxt;
  logic             len_err_nxt;
  logic [IDX_W-1:0] g, sel_idx, scan_idx;
  logic             beat;

  assign g = grant_idx[IDX_W-1:0];

  // Scan from rr_ptr upward; iterating downward lets the nearest valid win.
  always_comb begin
    sel_idx  = '0;
    scan_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      scan_idx = IDX_W'((int'(rr_ptr) + i) % NUM_REQ);
      if (req_valid[scan_idx]) sel_idx = scan_idx;
    end
  end

  always_comb begin
    state_nxt    = state;
    grant_nxt    = grant_idx;
    rr_ptr_nxt   = rr_ptr;
    beat_cnt_nxt = beat_cnt;
    len_err_nxt  = len_err;
    req_ready    = '0;
    beat         = 1'b0;
    wr_data      = req_data[int'(g)*DATA_WIDTH +: DATA_WIDTH];
    busy         = (state == BURST);

    case (state)
      IDLE: begin
        if (!fifo_prog_full && (|req_valid)) begin
          state_nxt    = BURST;
          grant_nxt    = 3'(sel_idx);
          beat_cnt_nxt = '0;
        end
      end
      BURST: begin
        req_ready[g] = ~fifo_full;
        beat         = req_valid[g] & ~fifo_full;
        if (beat) begin
          if (req_last[g] || (beat_cnt == CNT_W'(MAX_BEATS - 1))) begin
            state_nxt  = IDLE;
            rr_ptr_nxt = (grant_idx == 3'(NUM_REQ - 1)) ? 3'd0 : grant_idx + 3'd1;
            if (!req_last[g]) len_err_nxt = 1'b1;
          end else begin
            beat_cnt_nxt = beat_cnt + CNT_W'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Reset blocks handshakes immediately, before the edge that clears state.
    if (!rst_n) begin
      req_ready = '0;
      beat      = 1'b0;
    end
    wr_en = beat;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      grant_idx <= '0;
      rr_ptr    <= '0;
      beat_cnt  <= '0;
      len_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      grant_idx <= grant_nxt;
      rr_ptr    <= rr_ptr_nxt;
      beat_cnt  <= beat_cnt_nxt;
      len_err   <= len_err_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: per-requester beat sources, expected-write scoreboard,
// one task per scenario.
module tb_fifo_wr_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;

  typedef struct packed {logic [DW-1:0] d; logic l;} beat_t;
  typedef struct packed {logic [2:0] g; logic [DW-1:0] d;} exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [NR-1:0]    req_valid = '0;
  logic [NR*DW-1:0] req_data = '0;
  logic [NR-1:0]    req_last = '0;
  logic [NR-1:0]    req_ready;
  logic             fifo_full = 1'b0;
  logic             fifo_prog_full = 1'b0;
  logic             wr_en;
  logic [DW-1:0]    wr_data;
  logic [2:0]       grant_idx;
  logic             busy;
  logic             len_err;

  fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BEATS(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .fifo_full(fifo_full),
    .fifo_prog_full(fifo_prog_full), .wr_en(wr_en), .wr_data(wr_data),
    .grant_idx(grant_idx), .busy(busy), .len_err(len_err)
  );

  always #5 clk = ~clk;

  beat_t         src_q[NR][$];
  exp_t          exp_q[$];
  int            wr_cyc[$];
  logic [NR-1:0] hold_off = '0;
  logic [NR-1:0] acc;
  int            errors = 0;
  int            checks = 0;
  int            cyc = 0;
  int            wr_count = 0;

  // Requester model: advance to next beat after an accepted cycle.
  always begin
    @(negedge clk);
    acc = req_valid & req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) begin
      beat_t b;
      if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
      if (src_q[i].size() > 0 && !hold_off[i]) begin
        b = src_q[i][0];
        req_valid[i] = 1'b1;
        req_data[i*DW +: DW] = b.d;
        req_last[i] = b.l;
      end else begin
        req_valid[i] = 1'b0;
        req_last[i]  = 1'b0;
      end
    end
  end

  // Write monitor and scoreboard.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (wr_en === 1'b1) begin
      wr_count++;
      wr_cyc.push_back(cyc);
      checks++;
      if (fifo_full !== 1'b0) begin
        errors++;
        $display("FAIL wr_en_while_full cyc=%0d got wr_en=1 exp wr_en=0", cyc);
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write cyc=%0d got g=%0d d=%h exp none", cyc, grant_idx, wr_data);
      end else begin
        e = exp_q.pop_front();
        if ({grant_idx, wr_data} !== {e.g, e.d}) begin
          errors++;
          $display("FAIL write_data cyc=%0d got g=%0d d=%h exp g=%0d d=%h",
                   cyc, grant_idx, wr_data, e.g, e.d);
        end
      end
    end
  end

  task automatic load_src(input int r, input int n, input logic [DW-1:0] base, input bit with_last);
    for (int k = 0; k < n; k++) src_q[r].push_back('{d: base + DW'(k), l: (with_last && k == n - 1)});
  endtask

  task automatic expect_beats(input int r, input int n, input logic [DW-1:0] base);
    for (int k = 0; k < n; k++) exp_q.push_back('{g: 3'(r), d: base + DW'(k)});
  endtask

  function automatic bit src_empty();
    for (int i = 0; i < NR; i++) if (src_q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drain(input string name, input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(exp_q.size() == 0 && busy === 1'b0 && src_empty()) && n < budget);
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s_drain got pending=%0d busy=%b exp pending=0 busy=0", name, exp_q.size(), busy);
      exp_q.delete();
      for (int i = 0; i < NR; i++) src_q[i].delete();
    end
  endtask

  task automatic wait_writes(input string name, input int target);
    int n = 0;
    while (wr_count < target && n < 100) begin
      @(posedge clk);
      #2;
      n++;
    end
    checks++;
    if (wr_count < target) begin
      errors++;
      $display("FAIL %s_wait got writes=%0d exp writes=%0d", name, wr_count, target);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    fifo_full = 1'b0;
    fifo_prog_full = 1'b0;
    hold_off = '0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    load_src(0, 2, 8'h00, 1'b1);
    load_src(2, 1, 8'h10, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({req_ready, wr_en, busy, grant_idx, len_err} !== 10'b0) begin
      errors++;
      $display("FAIL reset_state got ready=%b wr_en=%b busy=%b g=%0d len_err=%b exp all 0",
               req_ready, wr_en, busy, grant_idx, len_err);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    expect_beats(0, 2, 8'h00);
    expect_beats(2, 1, 8'h10);
    drain("reset_priority", 100);
  endtask

  task automatic test_two_req();
    int base;
    do_reset();
    base = wr_cyc.size();
    load_src(1, 2, 8'h40, 1'b1);
    load_src(3, 2, 8'h50, 1'b1);
    expect_beats(1, 2, 8'h40);
    expect_beats(3, 2, 8'h50);
    drain("two_req", 100);
    checks++;
    if (wr_cyc.size() < base + 4) begin
      errors++;
      $display("FAIL two_req_count got %0d exp 4", wr_cyc.size() - base);
    end else if (wr_cyc[base+1] - wr_cyc[base] != 1 || wr_cyc[base+2] - wr_cyc[base+1] != 2 ||
                 wr_cyc[base+3] - wr_cyc[base+2] != 1) begin
      errors++;
      $display("FAIL two_req_spacing got gaps %0d,%0d,%0d exp 1,2,1", wr_cyc[base+1] - wr_cyc[base],
               wr_cyc[base+2] - wr_cyc[base+1], wr_cyc[base+3] - wr_cyc[base+2]);
    end
    // rr_ptr should have wrapped to 0.
    load_src(0, 1, 8'h60, 1'b1);
    load_src(1, 1, 8'h61, 1'b1);
    load_src(3, 1, 8'h63, 1'b1);
    expect_beats(0, 1, 8'h60);
    expect_beats(1, 1, 8'h61);
    expect_beats(3, 1, 8'h63);
    drain("rr_wrap", 100);
  endtask

  task automatic test_round_robin();
    int base;
    do_reset();
    base = wr_cyc.size();
    for (int i = 0; i < NR; i++) begin
      load_src(i, 1, 8'h70 + DW'(i), 1'b1);
      load_src(i, 1, 8'h78 + DW'(i), 1'b1);
    end
    for (int i = 0; i < NR; i++) expect_beats(i, 1, 8'h70 + DW'(i));
    for (int i = 0; i < NR; i++) expect_beats(i, 1, 8'h78 + DW'(i));
    drain("round_robin", 100);
    for (int k = 1; k < 8; k++) begin
      checks++;
      if (wr_cyc.size() <= base + k) begin
        errors++;
        $display("FAIL rr_spacing_%0d got writes=%0d exp 8", k, wr_cyc.size() - base);
      end else if (wr_cyc[base+k] - wr_cyc[base+k-1] != 2) begin
        errors++;
        $display("FAIL rr_spacing_%0d got gap=%0d exp 2", k, wr_cyc[base+k] - wr_cyc[base+k-1]);
      end
    end
  endtask

  task automatic test_prog_full();
    do_reset();
    @(posedge clk);
    #2;
    fifo_prog_full = 1'b1;
    load_src(0, 3, 8'h80, 1'b1);
    expect_beats(0, 3, 8'h80);
    repeat (4) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || wr_en !== 1'b0) begin
        errors++;
        $display("FAIL prog_full_hold got busy=%b wr_en=%b exp busy=0 wr_en=0", busy, wr_en);
      end
    end
    @(posedge clk);
    #2;
    fifo_prog_full = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL prog_full_release_early got busy=%b exp 0", busy);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || grant_idx !== 3'd0) begin
      errors++;
      $display("FAIL prog_full_grant got busy=%b g=%0d exp busy=1 g=0", busy, grant_idx);
    end
    // Packet in progress continues past prog_full.
    @(posedge clk);
    #2;
    fifo_prog_full = 1'b1;
    drain("prog_full_burst", 50);
    fifo_prog_full = 1'b0;
  endtask

  task automatic test_full_stall();
    int c0;
    do_reset();
    c0 = wr_count;
    load_src(1, 4, 8'h90, 1'b1);
    load_src(2, 1, 8'hA0, 1'b1);
    expect_beats(1, 4, 8'h90);
    expect_beats(2, 1, 8'hA0);
    wait_writes("full_stall", c0 + 2);
    fifo_full = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (wr_en !== 1'b0 || req_ready !== 4'b0000) begin
        errors++;
        $display("FAIL full_stall got wr_en=%b ready=%b exp wr_en=0 ready=0000", wr_en, req_ready);
      end
      @(posedge clk);
      #2;
    end
    fifo_full = 1'b0;
    hold_off[1] = 1'b1;
    @(posedge clk);
    #2;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || grant_idx !== 3'd1 || wr_en !== 1'b0 || req_ready !== 4'b0010) begin
        errors++;
        $display("FAIL grant_hold got busy=%b g=%0d wr_en=%b ready=%b exp busy=1 g=1 wr_en=0 ready=0010",
                 busy, grant_idx, wr_en, req_ready);
      end
      @(posedge clk);
      #2;
    end
    hold_off[1] = 1'b0;
    drain("full_stall", 100);
    checks++;
    if (len_err !== 1'b0) begin
      errors++;
      $display("FAIL last_at_max_beats got len_err=%b exp 0", len_err);
    end
  endtask

  task automatic test_forced_release();
    int c0;
    do_reset();
    c0 = wr_count;
    load_src(2, 6, 8'h20, 1'b1);
    load_src(3, 1, 8'h30, 1'b1);
    expect_beats(2, 4, 8'h20);
    expect_beats(3, 1, 8'h30);
    expect_beats(2, 2, 8'h24);
    wait_writes("forced", c0 + 3);
    @(negedge clk);
    checks++;
    if (len_err !== 1'b0) begin
      errors++;
      $display("FAIL len_err_early got %b exp 0", len_err);
    end
    drain("forced", 100);
    checks++;
    if (len_err !== 1'b1) begin
      errors++;
      $display("FAIL len_err_set got %b exp 1", len_err);
    end
  endtask

  task automatic test_reset_mid();
    int c0;
    repeat (3) @(negedge clk);
    checks++;
    if (len_err !== 1'b1) begin
      errors++;
      $display("FAIL len_err_sticky got %b exp 1", len_err);
    end
    c0 = wr_count;
    load_src(3, 5, 8'hC0, 1'b1);
    expect_beats(3, 1, 8'hC0);
    wait_writes("reset_mid", c0 + 1);
    rst_n = 1'b0;
    src_q[3].delete();
    @(negedge clk);
    checks++;
    if (wr_en !== 1'b0 || req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL reset_mid_gate got wr_en=%b ready=%b exp wr_en=0 ready=0000", wr_en, req_ready);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || grant_idx !== 3'd0 || len_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_state got busy=%b g=%0d len_err=%b exp busy=0 g=0 len_err=0",
               busy, grant_idx, len_err);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (wr_count != c0 + 1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL reset_mid_abandon got writes=%0d pending=%0d exp writes=%0d pending=0",
               wr_count - c0, exp_q.size(), 1);
    end
  endtask

  initial begin
    test_reset();
    test_two_req();
    test_round_robin();
    test_prog_full();
    test_full_stall();
    test_forced_release();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters, range 2..8.
REQ-002 Parameter DATA_WIDTH, default 8: beat width; matches the FIFO write data width.
REQ-003 Parameter MAX_BEATS, default 64: maximum beats per packet before forced release, range 2..65535.
REQ-004 Port clk, input, 1: single clock for all logic; same domain as the FIFO write clock.
REQ-005 Port rst_n, input, 1: synchronous, active-low reset sampled on rising clk.
REQ-006 Port req_valid, input, NUM_REQ: per-requester beat valid.
REQ-007 Port req_data, input, NUM_REQ*DATA_WIDTH: requester i's data occupies slice [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 Port req_last, input, NUM_REQ: per-requester last beat of packet.
REQ-009 Port req_ready, output, NUM_REQ: per-requester beat accepted this cycle when valid and ready are both 1.
REQ-010 Port fifo_full, input, 1: FIFO true full.
REQ-011 Port fifo_prog_full, input, 1: FIFO programmable full; gates new packet grants.
REQ-012 Port wr_en, output, 1: FIFO write enable.
REQ-013 Port wr_data, output, DATA_WIDTH: FIFO write data.
REQ-014 Port grant_idx, output, 3: index of the current or last granted requester.
REQ-015 Port busy, output, 1: 1 while in BURST.
REQ-016 Port len_err, output, 1: sticky flag set on forced release; cleared only by reset.

Function
REQ-017 FSM states: IDLE and BURST; all state, grant_idx, rr_ptr, beat_cnt and len_err are registered.
REQ-018 IDLE: req_ready all 0 and wr_en 0.
REQ-019 IDLE to BURST on the next rising edge when fifo_prog_full=0 and |req_valid=1; no transition while fifo_prog_full=1.
REQ-020 Selection: first requester with req_valid=1, scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ; the result is latched into grant_idx.
REQ-021 BURST, g=grant_idx: req_ready[g] = ~fifo_full (combinational); all other req_ready bits = 0.
REQ-022 BURST: wr_en = req_valid[g] & ~fifo_full (combinational, zero added latency); wr_data = slice g of req_data.
REQ-023 wr_en never asserts while fifo_full=1.
REQ-024 BURST ignores fifo_prog_full; a packet in progress continues until true full.
REQ-025 A beat is an accepted cycle (wr_en=1); beat_cnt counts beats in the current packet, resets to 0 on grant, width clog2(MAX_BEATS)+1.
REQ-026 Normal release: a beat with req_last[g]=1 moves the FSM to IDLE on the next edge, with rr_ptr <= (g+1) mod NUM_REQ.
REQ-027 Forced release: a beat without last when beat_cnt = MAX_BEATS-1 (MAX_BEATS-th beat) has the same effect as REQ-026 and also sets len_err.
REQ-028 No IDLE bypass: at least one IDLE cycle separates consecutive packets, so the minimum grant latency is 1 cycle from req_valid in IDLE.
REQ-029 Requester deasserting valid mid-packet: the grant is held, with no timeout.
REQ-030 Requester valid changes for non-granted requesters during BURST have no effect.
REQ-031 busy=1 exactly when state=BURST.

Reset
REQ-032 rst_n=0 at a rising edge sets: state=IDLE, grant_idx=0, rr_ptr=0, beat_cnt=0, len_err=0.
REQ-033 During reset, req_ready=0 and wr_en=0 combinationally whenever rst_n=0 is sampled.
REQ-034 Reset mid-packet abandons the packet and issues no further writes.
REQ-035 After reset deasserts, requester 0 has first priority.

Verification
REQ-036 Requesters 1 and 3 valid, rr_ptr=0, each with a 2-beat packet -> grant 1, two writes; IDLE; grant 3, two writes; rr_ptr=0.
REQ-037 All 4 requesters continuously valid with 1-beat packets -> grant order 0,1,2,3,0; each write separated by one IDLE cycle.
REQ-038 fifo_prog_full=1 in IDLE with req_valid=4'b0001 -> no grant; fifo_prog_full drops -> grant 0 on the next edge.
REQ-039 fifo_full=1 for 3 cycles mid-packet -> wr_en=0 and req_ready=0 for those 3 cycles; data order preserved; no beat lost.
REQ-040 MAX_BEATS=4, requester 2 sends 6 beats without last -> 4 writes, forced release, len_err=1, rr_ptr=3; len_err remains 1 until rst_n=0.
REQ-041 rst_n=0 on beat 2 of a 5-beat packet -> wr_en=0 that cycle; the next edge gives IDLE, grant_idx=0, len_err=0.
